// File: rtl/i2c_tgt_pkg.sv
// Shared types and CPU register-select codes for the I2C target peripheral.
package i2c_tgt_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_tgt_state_e;

  localparam logic [3:0] I2C_TGT_OWNADDR = 4'h1;
  localparam logic [3:0] I2C_TGT_PTR     = 4'h2;
  localparam logic [3:0] I2C_TGT_BANK    = 4'h4;
  localparam logic [3:0] I2C_TGT_STATUS  = 4'h8;

  // SDA pad encoding {drive_enable, drive_value}
  localparam logic [1:0] PAD_REL  = 2'b01;
  localparam logic [1:0] PAD_DRV0 = 2'b10;

endpackage

// File: rtl/i2c_tgt_sync.sv
// SCL/SDA synchronizers with one history stage; derives edge and START/STOP pulses.
module i2c_tgt_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [2:0] scl_r;
  logic [2:0] sda_r;
  logic       sda_rise_s;
  logic       sda_fall_s;

  // Shift pins through two sync flops and a history flop; reset to idle-high bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_r <= 3'b111;
      sda_r <= 3'b111;
    end else begin
      scl_r <= {scl_r[1:0], scl_i};
      sda_r <= {sda_r[1:0], sda_i};
    end
  end

  assign sda        = sda_r[1];
  assign scl_rise   = scl_r[1] & ~scl_r[2];
  assign scl_fall   = ~scl_r[1] & scl_r[2];
  assign sda_rise_s = sda_r[1] & ~sda_r[2];
  assign sda_fall_s = ~sda_r[1] & sda_r[2];
  assign start      = sda_fall_s & scl_r[1];
  assign stop       = sda_rise_s & scl_r[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target with a CPU-visible byte bank and LM75-style pointer addressing.
module i2c_target
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0]  ADDR_RESET = 7'b1001000,
  parameter int unsigned NREG       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic        req_i,
  output logic [31:0] data_o,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t_o
);

  localparam int unsigned PW = $clog2(NREG);

  logic           sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  i2c_tgt_state_e state_r, state_nxt_s;
  logic [1:0]     pad_r, pad_nxt_s;
  logic [3:0]     cnt_r;
  logic [7:0]     shift_r, tx_r;
  logic [PW-1:0]  ptr_r;
  logic [7:0]     bank_r [NREG];
  logic [6:0]     own_addr_r, cur_addr_r;
  logic           rw_r, first_byte_r, wrote_r, wr_done_r;
  logic [7:0]     byte_in_s;
  logic           addr_match_s, cnt_full_s, busy_s, cpu_wr_s, sel_bank_s, unused_s;
  logic [3:0]     sel_s;

  i2c_tgt_sync u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda_s),
    .scl_rise (scl_rise_s),
    .scl_fall (scl_fall_s),
    .start    (start_s),
    .stop     (stop_s)
  );

  assign byte_in_s    = {shift_r[6:0], sda_s};
  assign addr_match_s = (shift_r[7:1] == cur_addr_r);
  assign cnt_full_s   = (cnt_r == 4'd8);
  assign busy_s       = (state_r != IDLE);
  assign sel_s        = addr_i[19:16];
  assign cpu_wr_s     = req_i & we_i;
  assign sel_bank_s   = (sel_s >= I2C_TGT_BANK) && (sel_s < (I2C_TGT_BANK + 4'(NREG)));
  assign unused_s     = ^{addr_i[31:20], addr_i[15:0], data_i[31:8]};
  assign sda_t_o      = pad_r[1];
  assign sda_o        = pad_r[0];

  // State and SDA pad registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      pad_r   <= PAD_REL;
    end else begin
      state_r <= state_nxt_s;
      pad_r   <= pad_nxt_s;
    end
  end

  // Next-state logic; bus START/STOP override every state.
  always_comb begin
    state_nxt_s = state_r;
    if (start_s) begin
      state_nxt_s = ADDR;
    end else if (stop_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        ADDR:     state_nxt_s = (scl_fall_s && cnt_full_s) ? (addr_match_s ? ADDR_ACK : WAIT_STOP) : ADDR;
        ADDR_ACK: state_nxt_s = scl_fall_s ? (rw_r ? RD_BYTE : WR_BYTE) : ADDR_ACK;
        WR_BYTE:  state_nxt_s = (scl_fall_s && cnt_full_s) ? WR_ACK : WR_BYTE;
        WR_ACK:   state_nxt_s = scl_fall_s ? WR_BYTE : WR_ACK;
        RD_BYTE:  state_nxt_s = (scl_fall_s && cnt_full_s) ? RD_ACK : RD_BYTE;
        RD_ACK:   state_nxt_s = scl_rise_s ? (sda_s ? WAIT_STOP : RD_BYTE) : RD_ACK;
        default:  state_nxt_s = state_r;
      endcase
    end
  end

  // Next SDA pad value; all changes happen on SCL falling edges or bus conditions.
  always_comb begin
    pad_nxt_s = pad_r;
    if (start_s || stop_s) begin
      pad_nxt_s = PAD_REL;
    end else begin
      case (state_r)
        ADDR:     pad_nxt_s = (scl_fall_s && cnt_full_s && addr_match_s) ? PAD_DRV0 : pad_r;
        ADDR_ACK: pad_nxt_s = scl_fall_s ? (rw_r ? {1'b1, bank_r[ptr_r][7]} : PAD_REL) : pad_r;
        WR_BYTE:  pad_nxt_s = (scl_fall_s && cnt_full_s) ? PAD_DRV0 : pad_r;
        WR_ACK:   pad_nxt_s = scl_fall_s ? PAD_REL : pad_r;
        RD_BYTE: begin
          if (!scl_fall_s) begin
            pad_nxt_s = pad_r;
          end else if (cnt_r == 4'd0) begin
            pad_nxt_s = {1'b1, bank_r[ptr_r][7]};
          end else if (cnt_full_s) begin
            pad_nxt_s = PAD_REL;
          end else begin
            pad_nxt_s = {1'b1, tx_r[3'd7 - cnt_r[2:0]]};
          end
        end
        default:  pad_nxt_s = PAD_REL;
      endcase
    end
  end

  // Datapath: CPU accesses first so that I2C updates win same-cycle collisions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r        <= 4'd0;
      shift_r      <= 8'h00;
      tx_r         <= 8'h00;
      ptr_r        <= '0;
      own_addr_r   <= ADDR_RESET;
      cur_addr_r   <= ADDR_RESET;
      rw_r         <= 1'b0;
      first_byte_r <= 1'b0;
      wrote_r      <= 1'b0;
      wr_done_r    <= 1'b0;
      for (int i = 0; i < NREG; i++) bank_r[i] <= 8'h00;
    end else begin
      if (cpu_wr_s) begin
        if (sel_s == I2C_TGT_OWNADDR) own_addr_r <= data_i[6:0];
        if (sel_bank_s) bank_r[sel_s[PW-1:0]] <= data_i[7:0];
        if ((sel_s == I2C_TGT_STATUS) && data_i[1]) wr_done_r <= 1'b0;
      end
      if (start_s) begin
        cnt_r      <= 4'd0;
        cur_addr_r <= own_addr_r;
      end else if (stop_s) begin
        if (wrote_r) wr_done_r <= 1'b1;
        wrote_r <= 1'b0;
      end else begin
        case (state_r)
          ADDR: begin
            if (scl_rise_s) begin
              shift_r <= byte_in_s;
              cnt_r   <= cnt_r + 4'd1;
            end
            if (scl_fall_s && cnt_full_s) rw_r <= shift_r[0];
          end
          ADDR_ACK: begin
            if (scl_fall_s) begin
              cnt_r        <= rw_r ? 4'd1 : 4'd0;
              first_byte_r <= ~rw_r;
              if (rw_r) tx_r <= bank_r[ptr_r];
            end
          end
          WR_BYTE: begin
            if (scl_rise_s) begin
              shift_r <= byte_in_s;
              cnt_r   <= cnt_r + 4'd1;
              if (cnt_r == 4'd7) begin
                if (first_byte_r) begin
                  ptr_r        <= byte_in_s[PW-1:0];
                  first_byte_r <= 1'b0;
                end else begin
                  bank_r[ptr_r] <= byte_in_s;
                  ptr_r         <= ptr_r + PW'(1);
                  wrote_r       <= 1'b1;
                end
              end
            end
          end
          WR_ACK: if (scl_fall_s) cnt_r <= 4'd0;
          RD_BYTE: begin
            if (scl_fall_s && (cnt_r == 4'd0)) begin
              tx_r  <= bank_r[ptr_r];
              cnt_r <= 4'd1;
            end else if (scl_fall_s && !cnt_full_s) begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
          RD_ACK: begin
            if (scl_rise_s && !sda_s) begin
              ptr_r <= ptr_r + PW'(1);
              cnt_r <= 4'd0;
            end
          end
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  // CPU read mux; returns zero unless a read is in progress.
  always_comb begin
    data_o = 32'h0;
    if (req_i && !we_i) begin
      case (sel_s)
        I2C_TGT_OWNADDR: data_o = {25'h0, own_addr_r};
        I2C_TGT_PTR:     data_o = 32'(ptr_r);
        I2C_TGT_STATUS:  data_o = {30'h0, wr_done_r, busy_s};
        default:         data_o = sel_bank_s ? {24'h0, bank_r[sel_s[PW-1:0]]} : 32'h0;
      endcase
    end else begin
      data_o = 32'h0;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench for i2c_target: a bit-banged I2C master plus CPU accesses, checked via a scoreboard queue.
module tb_i2c_target;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] data_i, addr_i, data_o;
  logic        we_i, req_i;
  logic        scl_m, sda_m, sda_bus;
  logic        sda_o, sda_t_o;
  int          n_checks = 0;
  int          n_errors = 0;
  int          drive_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~(sda_t_o & ~sda_o);

  i2c_target dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .req_i   (req_i),
    .data_o  (data_o),
    .scl_i   (scl_m),
    .sda_i   (sda_bus),
    .sda_o   (sda_o),
    .sda_t_o (sda_t_o)
  );

  always @(posedge clk) if (sda_t_o) drive_cnt <= drive_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_expect(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    check_val(tag, got, e);
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q_wait(); scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait(); scl_m = 1'b0; q_wait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q_wait(); scl_m = 1'b1; q_wait(); sda_m = 1'b1; q_wait();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b; q_wait(); scl_m = 1'b1; q_wait();
    s = sda_bus; q_wait(); scl_m = 1'b0; q_wait();
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic s;
    sb_expect({31'h0, exp_ack});
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    sb_check(tag, {31'h0, s});
  endtask

  task automatic rd_byte(input logic [7:0] exp, input logic ack, input string tag);
    logic [7:0] d;
    logic s;
    sb_expect({24'h0, exp});
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(ack, s);
    sb_check(tag, {24'h0, d});
  endtask

  task automatic cpu_wr(input logic [3:0] sel, input logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = {12'h0, sel, 16'h0}; data_i = d;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic cpu_rd_chk(input logic [3:0] sel, input logic [31:0] exp, input string tag);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = {12'h0, sel, 16'h0};
    sb_expect(exp);
    #1;
    sb_check(tag, data_o);
    req_i = 1'b0;
  endtask

  initial begin
    logic [7:0] nib;
    logic       s;
    int         d0;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    sb_expect(32'h0); sb_check("rst_sda_t", {31'h0, sda_t_o});
    sb_expect(32'h1); sb_check("rst_sda_o", {31'h0, sda_o});
    rst_i = 1'b0;
    cpu_rd_chk(4'h1, 32'h48, "rst_own");
    cpu_rd_chk(4'h2, 32'h0, "rst_ptr");
    cpu_rd_chk(4'h8, 32'h0, "rst_status");
    cpu_rd_chk(4'h5, 32'h0, "rst_bank1");
    cpu_rd_chk(4'h3, 32'h0, "unmapped");

    // Write pointer 1, data 0xA5
    bus_start();
    wr_byte(8'h90, 1'b0, "t1_addr_ack");
    cpu_rd_chk(4'h8, 32'h1, "t1_busy");
    wr_byte(8'h01, 1'b0, "t1_ptr_ack");
    wr_byte(8'hA5, 1'b0, "t1_data_ack");
    bus_stop();
    cpu_rd_chk(4'h5, 32'hA5, "t1_bank1");
    cpu_rd_chk(4'h2, 32'h2, "t1_ptr");
    cpu_rd_chk(4'h8, 32'h2, "t1_status");
    cpu_wr(4'h8, 32'h2);
    cpu_rd_chk(4'h8, 32'h0, "t1_status_clr");

    // Pointer write, repeated START, two-byte read
    cpu_wr(4'h4, 32'h19);
    cpu_wr(4'h5, 32'h80);
    bus_start();
    wr_byte(8'h90, 1'b0, "t2_addr_ack");
    wr_byte(8'h00, 1'b0, "t2_ptr_ack");
    bus_start();
    wr_byte(8'h91, 1'b0, "t2_raddr_ack");
    rd_byte(8'h19, 1'b0, "t2_rd0");
    rd_byte(8'h80, 1'b1, "t2_rd1");
    sb_expect(32'h0); sb_check("t2_release", {31'h0, sda_t_o});
    bus_stop();
    cpu_rd_chk(4'h2, 32'h1, "t2_ptr");

    // Foreign address: no ACK, bank untouched
    d0 = drive_cnt;
    bus_start();
    wr_byte(8'h92, 1'b1, "t3_addr_nack");
    wr_byte(8'h00, 1'b1, "t3_ptr_nack");
    wr_byte(8'h55, 1'b1, "t3_data_nack");
    bus_stop();
    sb_expect(32'h0); sb_check("t3_never_driven", 32'(drive_cnt - d0));
    cpu_rd_chk(4'h4, 32'h19, "t3_bank0");
    cpu_rd_chk(4'h5, 32'h80, "t3_bank1");

    // Five-byte write from pointer 2 wraps
    bus_start();
    wr_byte(8'h90, 1'b0, "t4_addr_ack");
    wr_byte(8'h02, 1'b0, "t4_ptr_ack");
    for (int i = 1; i <= 5; i++) wr_byte(8'(i * 17), 1'b0, "t4_data_ack");
    bus_stop();
    cpu_rd_chk(4'h4, 32'h33, "t4_bank0");
    cpu_rd_chk(4'h5, 32'h44, "t4_bank1");
    cpu_rd_chk(4'h6, 32'h55, "t4_bank2");
    cpu_rd_chk(4'h7, 32'h22, "t4_bank3");
    cpu_rd_chk(4'h2, 32'h3, "t4_ptr");
    cpu_rd_chk(4'h8, 32'h2, "t4_status");
    cpu_wr(4'h8, 32'h2);

    // STOP mid-read after four bits
    cpu_wr(4'h4, 32'hAF);
    bus_start();
    wr_byte(8'h90, 1'b0, "t5_addr_ack");
    wr_byte(8'h00, 1'b0, "t5_ptr_ack");
    bus_start();
    wr_byte(8'h91, 1'b0, "t5_raddr_ack");
    nib = 8'h0;
    for (int i = 3; i >= 0; i--) begin
      bus_bit(1'b1, s);
      nib[i] = s;
    end
    sb_expect(32'hA); sb_check("t5_nibble", {24'h0, nib});
    sda_m = 1'b0; q_wait(); scl_m = 1'b1; q_wait();
    sb_expect(32'h1); sb_check("t5_driving", {31'h0, sda_t_o});
    sda_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sb_expect(32'h0); sb_check("t5_stop_release", {31'h0, sda_t_o});
    q_wait();
    cpu_rd_chk(4'h8, 32'h0, "t5_idle");

    // Reset during a data-byte ACK under a CPU-changed address
    cpu_wr(4'h1, 32'h22);
    cpu_rd_chk(4'h1, 32'h22, "t6_own_set");
    bus_start();
    wr_byte(8'h44, 1'b0, "t6_addr_ack");
    wr_byte(8'h01, 1'b0, "t6_ptr_ack");
    for (int i = 7; i >= 0; i--) bus_bit(i[0], s);
    sda_m = 1'b1; q_wait(); scl_m = 1'b1;
    repeat (2) @(negedge clk);
    sb_expect(32'h1); sb_check("t6_ack_drive", {31'h0, sda_t_o});
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    sb_expect(32'h0); sb_check("t6_rst_release", {31'h0, sda_t_o});
    @(negedge clk);
    rst_i = 1'b0;
    q_wait(); scl_m = 1'b0; q_wait();
    bus_stop();
    cpu_rd_chk(4'h1, 32'h48, "t6_own");
    cpu_rd_chk(4'h4, 32'h0, "t6_bank0");
    cpu_rd_chk(4'h5, 32'h0, "t6_bank1");
    cpu_rd_chk(4'h2, 32'h0, "t6_ptr");
    cpu_rd_chk(4'h8, 32'h0, "t6_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) peripheral on the core's memory-mapped peripheral bus. It responds on SCL/SDA as the far end of the team's I2C controller.
- Holds a small byte register bank plus a pointer register. I2C masters read and write the bank with LM75-style transactions; the CPU can read and write the same bank.
- Sits beside the I2C controller in the perips group. Board-level tristate uses the same sda_o/sda_t_o convention.

Parameters:
- ADDR_RESET, 7'b1001000, own 7-bit address after reset.
- NREG, 4, number of byte registers in the bank (power of two, ≥2).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- data_i  in  32  CPU write data
- addr_i  in  32  CPU address; addr_i[19:16] selects the register
- we_i  in  1  CPU write strobe
- req_i  in  1  CPU access valid
- data_o  out  32  CPU read data (combinational)
- scl_i  in  1  bus SCL (asynchronous)
- sda_i  in  1  bus SDA (asynchronous)
- sda_o  out  1  SDA drive value
- sda_t_o  out  1  1 = drive sda_o onto SDA, 0 = release
- Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values:
  - sda_o=1, sda_t_o=0, state IDLE, pointer=0, bank=0, own address=ADDR_RESET, status=0.
  - Reset mid-transaction releases SDA on the next edge.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-flop synchronizer plus one history flop.
  - scl_rise/scl_fall/sda_rise/sda_fall are single-cycle pulses.
  - Pin-to-output latency: 3 clk cycles. Requirement: clk_i ≥ 20× SCL frequency.
- Bus condition detection:
  - START = sda_fall while SCL high. STOP = sda_rise while SCL high.
  - Both take priority over every state.
  - START (incl. repeated) -> ADDR with bit_cnt=7. STOP -> IDLE. Both release SDA.
- CPU map, selected by addr_i[19:16]:
  - 0x1 own address[6:0], RW.
  - 0x2 pointer, RO.
  - 0x4+i bank[i], RW.
  - 0x8 status, RW1C on bit1: bit0 busy (state≠IDLE); bit1 wr_done, sticky, set at STOP after ≥1 data byte written.
  - data_o = 0 unless req_i && !we_i; unmapped addresses read 0.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- ADDR:
  - Shift SDA in on each scl_rise, MSB first.
  - After 8 bits, on the next scl_fall: if addr[7:1] matches own address -> ADDR_ACK; otherwise -> WAIT_STOP.
- ADDR_ACK:
  - Drive 0 from that scl_fall to the following scl_fall.
  - Then R/W=0 -> WR_BYTE, first_byte=1.
  - R/W=1 -> RD_BYTE, and drive bank[ptr][7] on the same scl_fall.
- WR_BYTE:
  - Sample 8 bits on scl_rise, then ACK as in ADDR_ACK (state WR_ACK).
  - On the 8th rise: if first_byte, ptr = byte mod NREG; else bank[ptr] = byte and ptr = ptr+1 mod NREG (wrap).
- RD_BYTE:
  - Present each next bit on scl_fall. Release SDA at the scl_fall after bit 0 -> RD_ACK.
- RD_ACK:
  - On scl_rise, sample the master's response.
  - ACK (0): ptr++ mod NREG, and the next scl_fall drives the new MSB (RD_BYTE).
  - NACK (1): go to WAIT_STOP, SDA released.
- WAIT_STOP: SDA released; exit only via START or STOP.
- Collisions:
  - CPU write and I2C write to the same bank byte in the same cycle: I2C wins.
  - CPU write to own address takes effect for the next ADDR phase.
  - A read transmits a byte snapshot taken at its first bit.

Decomposition:
- Shared package holds:
  - i2c_tgt_state_e typedef.
  - Register-select constants: I2C_TGT_OWNADDR=4'h1, PTR=4'h2, BANK=4'h4, STATUS=4'h8.
- Sub-module i2c_tgt_sync: 2-flop synchronizer plus edge/START/STOP pulse generation. One instance per design, used by the FSM.

Test Plan:
- Master writes addr 0x48 (W), ptr 0x01, data 0xA5 -> three ACKs; bank[1]=0xA5; ptr=2; status=0x2 after STOP; CPU RW1C write clears it.
- CPU loads bank[0..1]=0x19,0x80. Master sends 0x48 W, ptr 0, repeated START, 0x48 R, ACK, NACK -> bytes 0x19, 0x80; SDA released after NACK.
- Address 0x49 on the bus -> no ACK (SDA never driven); a following write does not change the bank.
- Write of 5 data bytes starting ptr=2 -> bank[2],[3],[0],[1],[2] written; ptr wraps, final value 3.
- STOP injected mid-read after 4 bits -> SDA released within 3 clk; state IDLE; busy=0.
- rst_i asserted mid-ACK -> next cycle sda_t_o=0, own address 0x48, bank 0.
